spi_multi_channel_receiver: RTL and testbench
=============================================

// Module: spi_multi_channel_receiver
// PURPOSE
//   Parametrised SPI master receiver for read-only serial sensors/ADCs (PMOD ALS class).
//   Polls N_CH slaves in round-robin on a shared sck/sdo, one active-low chip select each.
//   Each frame yields one DATA_W-bit word, tagged with its channel, on a valid/ready port.
//   Sits between the PMOD pins and the sensor-processing or display logic.
// PARAMETERS
//   N_CH        2     number of slaves / cs_n lines (>=1)
//   DATA_W      16    bits shifted per frame, MSB first (2..32)
//   CLK_DIV     16    system clocks per SCK period (even, >=4)
//   GAP_CYCLES  4096  idle clocks with all cs_n high between frames (>=1)
// PORTS
//   clock        in   1                system clock
//   reset_n      in   1                asynchronous reset, active low
//   enable       in   1                1 = poll continuously; 0 = stop after current frame
//   cs_n         out  N_CH             chip selects, active low, at most one low
//   sck          out  1                serial clock, idles high
//   sdo          in   1                shared serial data from slaves
//   out_valid    out  1                word available
//   out_ready    in   1                consumer accepts word when out_valid&&out_ready
//   out_channel  out  $clog2(max(N_CH,2))  channel index of out_data
//   out_data     out  DATA_W           received word
//   overrun      out  1                sticky: word dropped (SPI_RX_OVERRUN_EN only)
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): cs_n all 1, sck=1, out_valid=0, out_channel=0,
//     out_data=0, overrun=0, FSM=IDLE, next channel=0, shift reg=0. Partial frame discarded.
//   FSM: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
//     IDLE: all cs_n high; enable=1 -> SETUP.
//     SETUP: cs_n[ch]=0, sck=1 for CLK_DIV/2 clocks -> SHIFT.
//     SHIFT: DATA_W bit periods of CLK_DIV clocks: first half sck=0, second half sck=1.
//       sdo sampled on last clock of each high half; shift <= {shift[DATA_W-2:0], sdo}.
//       After bit DATA_W-1 sample -> GAP; cs_n all high, sck=1 next clock.
//     GAP: GAP_CYCLES clocks; ch <= (ch==N_CH-1) ? 0 : ch+1; then IDLE.
//   cs_n low time per frame = CLK_DIV/2 + DATA_W*CLK_DIV clocks (264 at defaults).
//   Result latency: out_valid, out_data, out_channel update 1 clock after last sample.
//   enable sampled only in IDLE; deassertion never truncates a frame or the gap.
//   Handshake: out_valid holds with stable out_data/out_channel until out_valid&&out_ready.
//     SPI never stalls. New word while previous unaccepted: overwrite (latest wins).
//     Accept and new word on same clock: new word loaded, out_valid stays 1.
//   Counters sized $clog2 of their bound; no wrap beyond bound; no sdo sync (sck-derived).
// CONFIGURATION
//   SPI_RX_OVERRUN_EN defined: overrun sets (sticky until reset) when a new word
//     overwrites an unaccepted one (not when accepted on the same clock).
//   Undefined: overrun port tied 0; no overrun logic.
// STRUCTURE
//   Package spi_rx_pkg: state enum (IDLE/SETUP/SHIFT/GAP), width helper functions.
//   Sub-module spi_rx_sck_gen: CLK_DIV divider; emits sck level, half-period and
//     sample ticks; cleared at SETUP entry. Top holds FSM, bit/gap counters, output reg.
// TESTING (N_CH=2, DATA_W=16, CLK_DIV=16, GAP_CYCLES=64, slave model on sdo)
//   Reset mid-SHIFT at bit 7 -> cs_n=2'b11, sck=1, out_valid=0 immediately; restart at ch0.
//   ch0 sends 16'hA5C3, out_ready=1 -> out_data=A5C3, out_channel=0; cs_n[0] low 264 clocks.
//   Next frame ch1 sends 16'h1234 -> out_channel=1, data 1234; 64 gap clocks between frames.
//   out_ready=0 over ch0 16'h0001 and ch1 16'h0002 -> data 0002, ch1; overrun=1 if _EN, else 0.
//   out_ready pulsed on the completion clock -> old word accepted, new word valid, overrun=0.
//   enable dropped mid-SHIFT -> frame and gap complete, then cs_n stays 2'b11, no more words.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and width helpers for the multi-channel SPI receiver.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Width of a counter that must hold values 0..bound-1 (never below 1 bit).
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

    // Width of a channel index: $clog2(max(n_ch, 2)).
    function automatic int ch_w(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/spi_rx_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV/2 clocks, flags half-period ends and sample points.
// Latency: sck_o is registered; ticks are combinational from the counter state.
// Backpressure: none; free-running while clr_i is low, held at (count 0, sck high) while high.
// Ports:
//   clock, reset_n   system clock, async active-low reset
//   clr_i            hold divider cleared (sck high, counter 0)
//   sck_o            serial clock level
//   half_tick_o      last clock of the current half period
//   sample_tick_o    last clock of a high half period (sdo sample point)
module spi_rx_sck_gen
    import spi_rx_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    output logic sck_o,
    output logic half_tick_o,
    output logic sample_tick_o
);

    localparam int              HALF      = CLK_DIV / 2;
    localparam int              CW        = cnt_w(HALF);
    localparam logic [CW-1:0]   HALF_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    assign half_tick_o   = (cnt_q == HALF_LAST);
    assign sample_tick_o = half_tick_o & sck_q;
    assign sck_o         = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (clr_i) begin
            cnt_d = '0;
            sck_d = 1'b1;
        end else if (half_tick_o) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sck_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_multi_channel_receiver.sv
// Round-robin SPI master receiver: polls N_CH read-only slaves, emits channel-tagged words.
// Latency: word valid 1 clock after the last sdo sample of a frame.
// Backpressure: SPI never stalls; an unaccepted word is overwritten by the next (latest wins).
// Ports:
//   clock, reset_n          system clock, async active-low reset
//   enable                  poll continuously while high; sampled only between frames
//   cs_n, sck, sdo          SPI pins (one active-low select per slave, sck idles high)
//   out_valid/out_ready     word handshake; out_channel/out_data stable while pending
//   overrun                 sticky dropped-word flag, built only with SPI_RX_OVERRUN_EN
module spi_multi_channel_receiver
    import spi_rx_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 16,
    parameter int GAP_CYCLES = 4096
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    output logic [N_CH-1:0]         cs_n,
    output logic                    sck,
    input  logic                    sdo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ch_w(N_CH)-1:0]   out_channel,
    output logic [DATA_W-1:0]       out_data,
    output logic                    overrun
);

    localparam int               CHW      = ch_w(N_CH);
    localparam int               BW       = cnt_w(DATA_W);
    localparam int               GW       = cnt_w(GAP_CYCLES);
    localparam logic [BW-1:0]    BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CHW-1:0]   CH_LAST  = CHW'(N_CH - 1);

    state_e              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                valid_q, valid_d;
    logic [CHW-1:0]      och_q, och_d;
    logic [DATA_W-1:0]   odat_q, odat_d;

    logic gen_clr, gen_sck, half_tick, sample_tick, frame_done;

    // Divider only runs while a slave is selected, so every frame starts phase-aligned.
    assign gen_clr = (state_q == ST_IDLE) || (state_q == ST_GAP);

    spi_rx_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clock         (clock),
        .reset_n       (reset_n),
        .clr_i         (gen_clr),
        .sck_o         (gen_sck),
        .half_tick_o   (half_tick),
        .sample_tick_o (sample_tick)
    );

    assign frame_done = (state_q == ST_SHIFT) && sample_tick && (bit_q == BIT_LAST);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (half_tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sample_tick) begin
                    shift_d = {shift_q[DATA_W-2:0], sdo};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                    ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: a completing frame wins over an accept on the same clock.
    always_comb begin
        valid_d = valid_q;
        och_d   = och_q;
        odat_d  = odat_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (frame_done) begin
            valid_d = 1'b1;
            och_d   = ch_q;
            odat_d  = {shift_q[DATA_W-2:0], sdo};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            och_q   <= '0;
            odat_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            och_q   <= och_d;
            odat_q  <= odat_d;
        end
    end

    always_comb begin
        cs_n = '1;
        if ((state_q == ST_SETUP) || (state_q == ST_SHIFT)) cs_n[ch_q] = 1'b0;
    end

    assign sck         = (state_q == ST_SHIFT) ? gen_sck : 1'b1;
    assign out_valid   = valid_q;
    assign out_channel = och_q;
    assign out_data    = odat_q;

`ifdef SPI_RX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (frame_done && valid_q && !out_ready) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_multi_channel_receiver.sv
// Directed bench for spi_multi_channel_receiver with a two-slave sdo model.
module tb_spi_multi_channel_receiver;

    localparam int N_CH         = 2;
    localparam int DATA_W       = 16;
    localparam int CLK_DIV      = 16;
    localparam int GAP_CYCLES   = 64;
    localparam int CS_LOW       = CLK_DIV / 2 + DATA_W * CLK_DIV;  // 264
    localparam int HIGH_BETWEEN = GAP_CYCLES + 1;                  // gap plus the IDLE clock
`ifdef SPI_RX_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        out_ready = 1'b0;
    logic        sdo;
    logic [1:0]  cs_n;
    logic        sck;
    logic        out_valid;
    logic [0:0]  out_channel;
    logic [15:0] out_data;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spi_multi_channel_receiver #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .cs_n(cs_n), .sck(sck), .sdo(sdo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_data(out_data), .overrun(overrun)
    );

    // Slave model: present MSB on select, advance one bit on each sck fall after a high half.
    logic [15:0] tx_word [2];
    int          nbit = 0;
    bit          hi_seen = 0;
    logic [1:0]  cs_prev = 2'b11;
    logic        sck_prev = 1'b1;
    logic [3:0]  bidx;

    always @(cs_n or sck) begin
        if (cs_n != 2'b11 && cs_prev == 2'b11) begin
            nbit    = 0;
            hi_seen = 0;
        end else if (cs_n != 2'b11) begin
            if (sck && !sck_prev) hi_seen = 1;
            if (!sck && sck_prev && hi_seen) begin
                nbit    = nbit + 1;
                hi_seen = 0;
            end
        end
        cs_prev  = cs_n;
        sck_prev = sck;
    end

    assign bidx = 4'(15 - nbit);
    assign sdo  = (cs_n == 2'b10) ? tx_word[0][bidx] :
                  (cs_n == 2'b01) ? tx_word[1][bidx] : 1'b0;

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n got %b want 11", cs_n); end
        n_checks++; if (sck !== 1'b1) begin n_fail++; $display("FAIL reset_sck got %b want 1", sck); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_channel !== 1'b0) begin n_fail++; $display("FAIL reset_channel got %b want 0", out_channel); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", out_data); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        int rises;
        logic prev;
        do_reset();
        tx_word[0] = 16'h1111;
        tx_word[1] = 16'h2222;
        enable = 1'b1;
        wait_valid(1000, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", seen); end
        rises = 0;
        prev  = 1'b1;
        for (int i = 0; i < 2000 && !(rises == 7 && sck == 1'b0 && cs_n == 2'b01); i++) begin
            @(negedge clock);
            if (cs_n == 2'b01 && sck && !prev) rises++;
            prev = sck;
        end
        n_checks++; if (rises !== 7) begin n_fail++; $display("FAIL mid_reach_bit7 got %0d rises want 7", rises); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL mid_cs_n got %b want 11", cs_n); end
        n_checks++; if (sck !== 1'b1) begin n_fail++; $display("FAIL mid_sck got %b want 1", sck); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL mid_data got %h want 0000", out_data); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 20 && cs_n == 2'b11; i++) @(negedge clock);
        n_checks++; if (cs_n !== 2'b10) begin n_fail++; $display("FAIL mid_restart_cs got %b want 10", cs_n); end
        wait_valid(1000, seen);
        n_checks++; if (!seen || out_data !== 16'h1111 || out_channel !== 1'b0) begin
            n_fail++; $display("FAIL mid_restart_word got v=%b ch=%b %h want v=1 ch=0 1111", seen, out_channel, out_data);
        end
        enable = 1'b0;
    endtask

    task automatic test_frames();
        bit seen;
        int low_cnt, high_cnt;
        do_reset();
        tx_word[0] = 16'hA5C3;
        tx_word[1] = 16'h1234;
        out_ready  = 1'b1;
        enable     = 1'b1;
        low_cnt = 0;
        seen    = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1;
            else if (cs_n == 2'b10) low_cnt++;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL f0_valid got %b want 1", seen); end
        n_checks++; if (out_data !== 16'hA5C3) begin n_fail++; $display("FAIL f0_data got %h want a5c3", out_data); end
        n_checks++; if (out_channel !== 1'b0) begin n_fail++; $display("FAIL f0_channel got %b want 0", out_channel); end
        n_checks++; if (low_cnt !== CS_LOW) begin n_fail++; $display("FAIL f0_cs_low got %0d want %0d", low_cnt, CS_LOW); end
        n_checks++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL f0_cs_release got %b want 11", cs_n); end
        high_cnt = 0;
        for (int i = 0; i < 200 && cs_n == 2'b11; i++) begin
            high_cnt++;
            @(negedge clock);
        end
        n_checks++; if (high_cnt !== HIGH_BETWEEN) begin n_fail++; $display("FAIL gap_len got %0d want %0d", high_cnt, HIGH_BETWEEN); end
        n_checks++; if (cs_n !== 2'b01) begin n_fail++; $display("FAIL f1_cs got %b want 01", cs_n); end
        wait_valid(1000, seen);
        n_checks++; if (!seen || out_data !== 16'h1234) begin n_fail++; $display("FAIL f1_data got v=%b %h want v=1 1234", seen, out_data); end
        n_checks++; if (out_channel !== 1'b1) begin n_fail++; $display("FAIL f1_channel got %b want 1", out_channel); end
        enable = 1'b0;
    endtask

    task automatic test_overrun();
        bit seen;
        do_reset();
        tx_word[0] = 16'h0001;
        tx_word[1] = 16'h0002;
        out_ready  = 1'b0;
        enable     = 1'b1;
        wait_valid(1000, seen);
        n_checks++; if (!seen || out_data !== 16'h0001 || out_channel !== 1'b0) begin
            n_fail++; $display("FAIL ovr_first got v=%b ch=%b %h want v=1 ch=0 0001", seen, out_channel, out_data);
        end
        for (int i = 0; i < 400 && cs_n != 2'b01; i++) @(negedge clock);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_hold_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 16'h0001) begin n_fail++; $display("FAIL ovr_hold_data got %h want 0001", out_data); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b want 0", overrun); end
        for (int i = 0; i < 400 && out_channel !== 1'b1; i++) @(negedge clock);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 16'h0002) begin n_fail++; $display("FAIL ovr_data got %h want 0002", out_data); end
        n_checks++; if (out_channel !== 1'b1) begin n_fail++; $display("FAIL ovr_channel got %b want 1", out_channel); end
        n_checks++; if (overrun !== OVR_EXP) begin n_fail++; $display("FAIL ovr_flag got %b want %b", overrun, OVR_EXP); end
        enable = 1'b0;
    endtask

    task automatic test_accept_same_clock();
        bit seen;
        int low_cnt;
        do_reset();
        tx_word[0] = 16'h0F0F;
        tx_word[1] = 16'hF0F0;
        out_ready  = 1'b0;
        enable     = 1'b1;
        wait_valid(1000, seen);
        n_checks++; if (!seen || out_data !== 16'h0F0F) begin n_fail++; $display("FAIL acc_first got v=%b %h want v=1 0f0f", seen, out_data); end
        low_cnt = 0;
        for (int i = 0; i < 1000 && low_cnt < CS_LOW; i++) begin
            @(negedge clock);
            if (cs_n == 2'b01) low_cnt++;
        end
        n_checks++; if (low_cnt !== CS_LOW) begin n_fail++; $display("FAIL acc_reach got %0d want %0d", low_cnt, CS_LOW); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL acc_valid got %b want 1", out_valid); end
        n_checks++; if (out_data !== 16'hF0F0) begin n_fail++; $display("FAIL acc_data got %h want f0f0", out_data); end
        n_checks++; if (out_channel !== 1'b1) begin n_fail++; $display("FAIL acc_channel got %b want 1", out_channel); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL acc_overrun got %b want 0", overrun); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL acc_drain got %b want 0", out_valid); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit seen;
        int low_cnt, high_cnt, vcnt;
        do_reset();
        tx_word[0] = 16'h5A5A;
        tx_word[1] = 16'hC3C3;
        out_ready  = 1'b1;
        enable     = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 1000 && low_cnt < 100; i++) begin
            @(negedge clock);
            if (cs_n == 2'b10) low_cnt++;
        end
        enable = 1'b0;
        wait_valid(1000, seen);
        n_checks++; if (!seen || out_data !== 16'h5A5A || out_channel !== 1'b0) begin
            n_fail++; $display("FAIL en_word got v=%b ch=%b %h want v=1 ch=0 5a5a", seen, out_channel, out_data);
        end
        high_cnt = 0;
        vcnt     = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (cs_n == 2'b11) high_cnt++;
            if (out_valid) vcnt++;
        end
        n_checks++; if (high_cnt !== 400) begin n_fail++; $display("FAIL en_idle_cs got %0d want 400", high_cnt); end
        n_checks++; if (vcnt !== 0) begin n_fail++; $display("FAIL en_no_words got %0d want 0", vcnt); end
        enable = 1'b1;
        for (int i = 0; i < 20 && cs_n == 2'b11; i++) @(negedge clock);
        n_checks++; if (cs_n !== 2'b01) begin n_fail++; $display("FAIL en_resume_ch got %b want 01", cs_n); end
        enable = 1'b0;
    endtask

    initial begin
        tx_word[0] = 16'h0000;
        tx_word[1] = 16'h0000;
        test_reset();
        test_reset_mid_shift();
        test_frames();
        test_overrun();
        test_accept_same_clock();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
